tinker_decode_issue: RTL and testbench

- Decode/issue stage that feeds the integer/logic/FP ALU.
- Accepts 32-bit Tinker instruction words over a valid/ready handshake and splits them into opcode/rd/rs/rt/literal fields.
- Reads operands from an internal 32x64 register file and presents a registered operand bundle to the ALU.
- Accepts the ALU result back on a writeback port; a per-register scoreboard stalls issue while an operand is still in flight.

---
 rtl/tinker_pkg.sv | 57 +++++
 rtl/tinker_decode_issue_if.sv | 33 +++
 rtl/tinker_regfile.sv | 37 +++
 rtl/tinker_decode_issue.sv | 93 +++++++++
 tb/tb_tinker_decode_issue.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/tinker_pkg.sv
// Shared ISA constants, instruction field positions and the issue bundle type
// for the Tinker decode/issue stage.
package tinker_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int XLEN     = 64;
  localparam logic [XLEN-1:0] STACK_INIT_DEFAULT = 64'h0008_0000;

  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTL  = 5'h06;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_MOV2   = 5'h11;
  localparam logic [4:0] OP_MOV3   = 5'h12;
  localparam logic [4:0] OP_FADD   = 5'h14;
  localparam logic [4:0] OP_FSUB   = 5'h15;
  localparam logic [4:0] OP_FMUL   = 5'h16;
  localparam logic [4:0] OP_FDIV   = 5'h17;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_ADDI   = 5'h19;
  localparam logic [4:0] OP_SUB    = 5'h1a;
  localparam logic [4:0] OP_SUBI   = 5'h1b;
  localparam logic [4:0] OP_MUL    = 5'h1c;
  localparam logic [4:0] OP_DIV    = 5'h1d;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int LIT_MSB = 11;
  localparam int LIT_LSB = 0;

  typedef struct packed {
    logic [4:0]      opcode;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [11:0]     literal;
  } issue_bundle_t;

  // Branch, load and store opcodes belong to other units and are not legal here.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op <= OP_SHFTLI) || (op == OP_MOV2) || (op == OP_MOV3) ||
           ((op >= OP_FADD) && (op <= OP_DIV));
  endfunction

endpackage

// File: rtl/tinker_decode_issue_if.sv
// Instruction-in, operand-bundle-out and writeback signals of the decode/issue stage.
interface tinker_decode_issue_if;
  import tinker_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_opcode;
  logic [4:0]      out_rd_idx;
  logic [XLEN-1:0] out_rd_val;
  logic [XLEN-1:0] out_rs_val;
  logic [XLEN-1:0] out_rt_val;
  logic [11:0]     out_literal;
  logic            wb_en;
  logic [4:0]      wb_idx;
  logic [XLEN-1:0] wb_data;
  logic            illegal_err;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_idx, wb_data,
    output in_ready, out_valid, out_opcode, out_rd_idx, out_rd_val,
           out_rs_val, out_rt_val, out_literal, illegal_err
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_idx, wb_data,
    input  in_ready, out_valid, out_opcode, out_rd_idx, out_rd_val,
           out_rs_val, out_rt_val, out_literal, illegal_err
  );

endinterface

// File: rtl/tinker_regfile.sv
// 32x64 register file: three async read ports with write-through bypass,
// one synchronous write port, r31 resets to the stack pointer value.
module tinker_regfile
  import tinker_pkg::*;
#(
  parameter logic [XLEN-1:0] STACK_INIT = STACK_INIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] ra_idx_i,
  input  logic [IDX_W-1:0] rb_idx_i,
  input  logic [IDX_W-1:0] rc_idx_i,
  output logic [XLEN-1:0]  ra_val_o,
  output logic [XLEN-1:0]  rb_val_o,
  output logic [XLEN-1:0]  rc_val_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] w_idx_i,
  input  logic [XLEN-1:0]  w_data_i
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == NUM_REGS - 1) ? STACK_INIT : '0;
      end
    end else if (we_i) begin
      regs_q[w_idx_i] <= w_data_i;
    end
  end

  assign ra_val_o = (we_i && (w_idx_i == ra_idx_i)) ? w_data_i : regs_q[ra_idx_i];
  assign rb_val_o = (we_i && (w_idx_i == rb_idx_i)) ? w_data_i : regs_q[rb_idx_i];
  assign rc_val_o = (we_i && (w_idx_i == rc_idx_i)) ? w_data_i : regs_q[rc_idx_i];

endmodule

// File: rtl/tinker_decode_issue.sv
// Decode/issue stage: splits Tinker words, reads operands, tracks in-flight
// destinations in a scoreboard and holds one registered bundle for the ALU.
module tinker_decode_issue
  import tinker_pkg::*;
#(
  parameter logic [XLEN-1:0] STACK_INIT = STACK_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tinker_decode_issue_if.slave io
);

  logic [4:0]          opc, rd, rs, rt;
  logic [11:0]         lit;
  logic [XLEN-1:0]     rd_val, rs_val, rt_val;
  logic                hazard, accept, legal;

  issue_bundle_t       bundle_q, bundle_d;
  logic                out_valid_q, out_valid_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                illegal_q, illegal_d;

  assign opc = io.in_instr[OPC_MSB:OPC_LSB];
  assign rd  = io.in_instr[RD_MSB:RD_LSB];
  assign rs  = io.in_instr[RS_MSB:RS_LSB];
  assign rt  = io.in_instr[RT_MSB:RT_LSB];
  assign lit = io.in_instr[LIT_MSB:LIT_LSB];

  tinker_regfile #(.STACK_INIT(STACK_INIT)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_idx_i (rd),
    .rb_idx_i (rs),
    .rc_idx_i (rt),
    .ra_val_o (rd_val),
    .rb_val_o (rs_val),
    .rc_val_o (rt_val),
    .we_i     (io.wb_en),
    .w_idx_i  (io.wb_idx),
    .w_data_i (io.wb_data)
  );

  // A writeback landing this cycle releases its register in time for the bypass.
  function automatic logic busy(input logic [4:0] idx);
    return pending_q[idx] && !(io.wb_en && (io.wb_idx == idx));
  endfunction

  assign hazard = busy(rd) || busy(rs) || busy(rt);
  assign io.in_ready = (!out_valid_q || io.out_ready) && !hazard;
  assign accept = io.in_valid && io.in_ready;
  assign legal  = is_alu_op(opc);

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    pending_d   = pending_q;
    illegal_d   = illegal_q;
    if (io.wb_en) pending_d[io.wb_idx] = 1'b0;
    if (accept && legal) begin
      out_valid_d = 1'b1;
      bundle_d    = '{opcode: opc, rd_idx: rd, rd_val: rd_val,
                      rs_val: rs_val, rt_val: rt_val, literal: lit};
      pending_d[rd] = 1'b1;
    end else begin
      if (io.out_ready) out_valid_d = 1'b0;
      if (accept) illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      pending_q   <= '0;
      illegal_q   <= 1'b0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      pending_q   <= pending_d;
      illegal_q   <= illegal_d;
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.out_opcode  = bundle_q.opcode;
  assign io.out_rd_idx  = bundle_q.rd_idx;
  assign io.out_rd_val  = bundle_q.rd_val;
  assign io.out_rs_val  = bundle_q.rs_val;
  assign io.out_rt_val  = bundle_q.rt_val;
  assign io.out_literal = bundle_q.literal;
  assign io.illegal_err = illegal_q;

endmodule

// File: tb/tb_tinker_decode_issue.sv
// Directed bench for tinker_decode_issue: reset, bypass, RAW stall,
// backpressure, illegal opcode and async reset mid-bundle.
module tb_tinker_decode_issue;
  import tinker_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tinker_decode_issue_if io ();

  tinker_decode_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] d,
                                      input logic [4:0] s, input logic [4:0] t,
                                      input logic [11:0] l);
    return {op, d, s, t, l};
  endfunction

  logic [31:0] b2b [4];

  initial begin
    io.in_valid  = 1'b0;
    io.in_instr  = '0;
    io.out_ready = 1'b1;
    io.wb_en     = 1'b0;
    io.wb_idx    = '0;
    io.wb_data   = '0;
    b2b[0] = enc(OP_SUB,  5'd10, 5'd0,  5'd31, 12'h00a);
    b2b[1] = enc(OP_ADD,  5'd11, 5'd31, 5'd0,  12'h00b);
    b2b[2] = enc(OP_FMUL, 5'd12, 5'd0,  5'd0,  12'h00c);
    b2b[3] = enc(OP_MOV2, 5'd13, 5'd31, 5'd31, 12'h00d);

    // Reset state
    #13;
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_illegal", 64'(io.illegal_err), 64'd0);
    chk("rst_rs_val", io.out_rs_val, 64'd0);
    rst_n = 1'b1;
    tick();

    // add r1,r31,r0 straight after reset
    io.in_instr = 32'hC07E0000;
    io.in_valid = 1'b1;
    #1 chk("add_in_ready", 64'(io.in_ready), 64'd1);
    tick();
    io.in_valid = 1'b0;
    chk("add_out_valid", 64'(io.out_valid), 64'd1);
    chk("add_opcode", 64'(io.out_opcode), 64'h18);
    chk("add_rd_idx", 64'(io.out_rd_idx), 64'd1);
    chk("add_rs_val", io.out_rs_val, 64'h80000);
    chk("add_rt_val", io.out_rt_val, 64'd0);
    tick();
    chk("add_retired", 64'(io.out_valid), 64'd0);

    // xor r4,r3,r3 with same-cycle writeback of r3
    io.in_instr = enc(OP_XOR, 5'd4, 5'd3, 5'd3, 12'h000);
    io.in_valid = 1'b1;
    io.wb_en = 1'b1; io.wb_idx = 5'd3; io.wb_data = 64'h55;
    tick();
    io.wb_en = 1'b0;
    chk("byp_rs_val", io.out_rs_val, 64'h55);
    chk("byp_rt_val", io.out_rt_val, 64'h55);
    io.in_instr = enc(OP_OR, 5'd8, 5'd3, 5'd0, 12'h000);
    tick();
    chk("rf3_written", io.out_rs_val, 64'h55);

    // RAW stall on r5
    io.in_instr = enc(OP_ADDI, 5'd5, 5'd0, 5'd0, 12'h001);
    tick();
    chk("addi_rd_idx", 64'(io.out_rd_idx), 64'd5);
    chk("addi_literal", 64'(io.out_literal), 64'd1);
    io.in_instr = enc(OP_ADD, 5'd6, 5'd5, 5'd5, 12'h000);
    #1 chk("raw_stall0", 64'(io.in_ready), 64'd0);
    tick();
    chk("raw_stall1", 64'(io.in_ready), 64'd0);
    chk("raw_no_issue", 64'(io.out_valid), 64'd0);
    tick();
    io.wb_en = 1'b1; io.wb_idx = 5'd5; io.wb_data = 64'h10;
    #1 chk("raw_release", 64'(io.in_ready), 64'd1);
    tick();
    io.wb_en = 1'b0;
    io.in_valid = 1'b0;
    chk("raw_out_valid", 64'(io.out_valid), 64'd1);
    chk("raw_rd_idx", 64'(io.out_rd_idx), 64'd6);
    chk("raw_rs_val", io.out_rs_val, 64'h10);
    chk("raw_rt_val", io.out_rt_val, 64'h10);

    // Backpressure holds the r6 bundle, then 4 back-to-back issues
    io.out_ready = 1'b0;
    io.in_instr = b2b[0];
    io.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 64'(io.in_ready), 64'd0);
      tick();
      chk("bp_hold_valid", 64'(io.out_valid), 64'd1);
      chk("bp_hold_rd_idx", 64'(io.out_rd_idx), 64'd6);
      chk("bp_hold_rs_val", io.out_rs_val, 64'h10);
    end
    io.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io.in_instr = b2b[i];
      #1 chk("b2b_in_ready", 64'(io.in_ready), 64'd1);
      tick();
      chk("b2b_valid", 64'(io.out_valid), 64'd1);
      chk("b2b_rd_idx", 64'(io.out_rd_idx), 64'(10 + i));
      chk("b2b_literal", 64'(io.out_literal), 64'(12'h00a + i));
    end
    io.in_valid = 1'b0;
    tick();
    chk("b2b_drain", 64'(io.out_valid), 64'd0);

    // Illegal opcode 0x0A, with a writeback to r31 in the same cycle
    io.in_instr = enc(5'h0a, 5'd21, 5'd0, 5'd0, 12'h000);
    io.in_valid = 1'b1;
    io.wb_en = 1'b1; io.wb_idx = 5'd31; io.wb_data = 64'h1234;
    tick();
    io.in_valid = 1'b0;
    io.wb_en = 1'b0;
    chk("ill_no_valid", 64'(io.out_valid), 64'd0);
    chk("ill_err", 64'(io.illegal_err), 64'd1);
    io.in_instr = enc(OP_AND, 5'd20, 5'd21, 5'd31, 12'h000);
    io.in_valid = 1'b1;
    #1 chk("ill_no_pending", 64'(io.in_ready), 64'd1);
    tick();
    io.in_valid = 1'b0;
    chk("ill_next_valid", 64'(io.out_valid), 64'd1);
    chk("ill_next_rt_val", io.out_rt_val, 64'h1234);
    chk("ill_sticky", 64'(io.illegal_err), 64'd1);

    // Async reset while a bundle for r7 is held
    io.in_instr = enc(OP_ADD, 5'd7, 5'd0, 5'd0, 12'h000);
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    chk("pre_rst_valid", 64'(io.out_valid), 64'd1);
    chk("pre_rst_rd_idx", 64'(io.out_rd_idx), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(io.out_valid), 64'd0);
    chk("arst_rd_idx", 64'(io.out_rd_idx), 64'd0);
    chk("arst_illegal", 64'(io.illegal_err), 64'd0);
    #1 rst_n = 1'b1;
    io.out_ready = 1'b1;
    io.in_instr = enc(OP_ADD, 5'd9, 5'd7, 5'd31, 12'h000);
    io.in_valid = 1'b1;
    #1 chk("arst_pending_clr", 64'(io.in_ready), 64'd1);
    tick();
    io.in_valid = 1'b0;
    chk("arst_issue", 64'(io.out_valid), 64'd1);
    chk("arst_r7", io.out_rs_val, 64'd0);
    chk("arst_r31", io.out_rt_val, 64'h80000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
